// File: rtl/fwrisc_lsu_ctrl_if.sv
// fwrisc_lsu_ctrl_if: the data-bus side of the load/store controller.
//   master : the controller. It drives daddr/dvalid/dwrite/dwdata/dwstb and
//            receives drdata/dready.
//   slave  : the memory or bus fabric. It receives the request and drives
//            drdata/dready.
interface fwrisc_lsu_ctrl_if;
  logic [31:0] daddr;
  logic        dvalid;
  logic        dwrite;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic [31:0] drdata;
  logic        dready;

  modport master (
    output daddr, dvalid, dwrite, dwdata, dwstb,
    input  drdata, dready
  );

  modport slave (
    input  daddr, dvalid, dwrite, dwdata, dwstb,
    output drdata, dready
  );
endinterface

// File: rtl/fwrisc_lsu_ctrl.sv
// fwrisc_lsu_ctrl: load/store unit controller for the fwrisc core.
// It accepts one load or store from the exec stage and issues it as a single
// word-aligned data-bus beat. It then reports completion with a one-cycle
// done pulse. On a load, it also writes the destination register.
//
// Ports:
//   clock, reset          rising-edge clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready is high while idle)
//   req_write, req_size   1=store / 0=load; 0=byte 1=half 2=word 3=illegal
//   req_unsigned          zero-extend loaded byte/half
//   req_addr, req_wdata   byte address, store data (LSB-justified)
//   req_rd                load destination register
//   done, err             completion pulse, error flag valid with done
//   rd_waddr/rd_wdata/rd_wen  register-file write port
//   dbus                  data bus (master side)
//
// state | meaning
// IDLE  | waiting for a request; req_ready=1
// BUS   | bus beat outstanding; dvalid=1; counting cycles for timeout
// DONE  | done pulse (with err/rd_wen as applicable); back to IDLE next
module fwrisc_lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [5:0]  req_rd,
  output logic        done,
  output logic        err,
  output logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  fwrisc_lsu_ctrl_if.master dbus
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  // Last count value before abort: BUS lasts at most TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       r_write;
  logic [1:0] r_size;
  logic       r_unsigned;
  logic [1:0] r_lane;
  logic [5:0] r_rd;

  logic        misaligned;
  logic [3:0]  st_stb;
  logic [31:0] st_data;

  assign req_ready = (state == IDLE);

  assign misaligned = (req_size == 2'd3) ||
                      (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  // Store data is replicated across all lanes, so the strobe alone selects
  // which bytes are written.
  always_comb begin
    st_stb  = 4'b1111;
    st_data = req_wdata;
    case (req_size)
      2'd0: begin
        st_stb  = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        st_stb  = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] extract(input logic [31:0] d,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lane,
                                          input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lane, 3'b000} +: 8];
    h = d[{lane[1], 4'b0000} +: 16];
    case (size)
      2'd0:    extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: extract = d;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      r_write     <= 1'b0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'd0;
      r_rd        <= 6'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      rd_wen      <= 1'b0;
      rd_waddr    <= 6'd0;
      rd_wdata    <= 32'd0;
      dbus.dvalid <= 1'b0;
      dbus.dwrite <= 1'b0;
      dbus.dwstb  <= 4'd0;
      dbus.daddr  <= 32'd0;
      dbus.dwdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_rd       <= req_rd;
            if (misaligned) begin
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b1;
              rd_waddr <= req_rd;
            end else begin
              state       <= BUS;
              cnt         <= 8'd0;
              dbus.dvalid <= 1'b1;
              dbus.dwrite <= req_write;
              dbus.daddr  <= {req_addr[31:2], 2'b00};
              dbus.dwdata <= st_data;
              dbus.dwstb  <= req_write ? st_stb : 4'b0000;
            end
          end
        end
        BUS: begin
          if (dbus.dready || cnt == CNT_LAST) begin
            state       <= DONE;
            done        <= 1'b1;
            dbus.dvalid <= 1'b0;
            dbus.dwrite <= 1'b0;
            dbus.dwstb  <= 4'b0000;
            rd_waddr    <= r_rd;
            if (dbus.dready) begin
              rd_wdata <= extract(dbus.drdata, r_size, r_lane, r_unsigned);
              rd_wen   <= !r_write && (r_rd != 6'd0);
            end else begin
              err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          err    <= 1'b0;
          rd_wen <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
